// File: rtl/arith_sweep_checker_if.sv
// ---------------------------------------------------------------------------
// arith_sweep_checker_if
// Stimulus/response bundle between the sweep checker and the 1-bit
// `arithmetic` block under test.
//   a_o, b_o           : stimulus driven by the checker
//   w_i, x_i, y_i, z_i : responses returned by the arithmetic block
// Modports:
//   master : checker side (drives a_o/b_o, observes w_i..z_i)
//   slave  : arithmetic block side
// ---------------------------------------------------------------------------
interface arith_sweep_checker_if;
    logic a_o;
    logic b_o;
    logic w_i;
    logic x_i;
    logic y_i;
    logic z_i;

    modport master (
        output a_o, b_o,
        input  w_i, x_i, y_i, z_i
    );

    modport slave (
        input  a_o, b_o,
        output w_i, x_i, y_i, z_i
    );
endinterface

// File: rtl/arith_sweep_checker.sv
// ---------------------------------------------------------------------------
// arith_sweep_checker
// On-board self-test engine for the 1-bit `arithmetic` block. A run sweeps
// the vectors 00, 01, 10, 11 (NUM_PASSES times), waits SETTLE_CYCLES after
// each vector is driven, then compares {w,x,y,z} with the half-adder /
// half-subtractor golden function and counts mismatching vectors.
//
// Parameters:
//   SETTLE_CYCLES : cycles between driving a vector and sampling it (0 ok)
//   NUM_PASSES    : full 4-vector sweeps per run (1..15)
//   ERR_W         : width of err_count (saturating)
//
// Ports:
//   clk       : system clock, rising edge
//   rst       : synchronous, active-high reset
//   start     : launch a run; only looked at in IDLE or DONE
//   arith     : stimulus/response bundle (master side)
//   busy      : run in progress
//   done      : run finished; held until next start or reset
//   pass      : done with zero mismatches
//   err_count : mismatching vectors in this run
//   vec_idx   : current vector, equals {a_o, b_o}
//
// Optional feature, enabled by defining ARITH_FIRST_FAIL_EN:
//   fail_valid : a mismatch has been captured in this run
//   fail_vec   : vector of the first mismatch
//   fail_obs   : {w,x,y,z} observed at the first mismatch
//
// state  | meaning
// IDLE   | after reset, waiting for start
// SETTLE | vector driven, waiting for the block to settle
// CHECK  | sample response, count mismatch, advance vector
// DONE   | run finished, results held, waiting for start
// ---------------------------------------------------------------------------
module arith_sweep_checker #(
    parameter int SETTLE_CYCLES = 1,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_W         = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    arith_sweep_checker_if.master arith,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic [1:0]           vec_idx
`ifdef ARITH_FIRST_FAIL_EN
    ,
    output logic                 fail_valid,
    output logic [1:0]           fail_vec,
    output logic [3:0]           fail_obs
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] CHECK  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST =
        CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    // Zero settle cycles skips SETTLE entirely, so each vector lasts 1 cycle.
    localparam logic [1:0] AFTER_LOAD = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
    localparam logic [3:0] PASS_LAST  = 4'(NUM_PASSES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    logic [1:0]       state;
    logic [1:0]       vec;
    logic [CNT_W-1:0] settle_cnt;
    logic [3:0]       pass_cnt;
    logic [3:0]       golden;
    logic [3:0]       observed;
    logic             mismatch;

    // w = sum, x = carry, y = difference, z = borrow
    always_comb begin
        golden   = {vec[1] ^ vec[0], vec[1] & vec[0], vec[1] ^ vec[0], ~vec[1] & vec[0]};
        observed = {arith.w_i, arith.x_i, arith.y_i, arith.z_i};
        mismatch = (observed != golden);
    end

    assign arith.a_o = vec[1];
    assign arith.b_o = vec[0];
    assign vec_idx   = vec;
    assign pass      = done && (err_count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vec        <= 2'd0;
            settle_cnt <= '0;
            pass_cnt   <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_count  <= '0;
`ifdef ARITH_FIRST_FAIL_EN
            fail_valid <= 1'b0;
            fail_vec   <= 2'd0;
            fail_obs   <= 4'd0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_count  <= '0;
                        pass_cnt   <= 4'd0;
                        settle_cnt <= '0;
                        done       <= 1'b0;
                        busy       <= 1'b1;
                        vec        <= 2'd0;
                        state      <= AFTER_LOAD;
`ifdef ARITH_FIRST_FAIL_EN
                        fail_valid <= 1'b0;
                        fail_vec   <= 2'd0;
                        fail_obs   <= 4'd0;
`endif
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (mismatch && (err_count != ERR_MAX)) begin
                        err_count <= err_count + 1'b1;
                    end
`ifdef ARITH_FIRST_FAIL_EN
                    if (mismatch && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_vec   <= vec;
                        fail_obs   <= observed;
                    end
`endif
                    if (vec == 2'd3) begin
                        if (pass_cnt == PASS_LAST) begin
                            // Last vector stays on a_o/b_o while results are held.
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            pass_cnt <= pass_cnt + 1'b1;
                            vec      <= 2'd0;
                            state    <= AFTER_LOAD;
                        end
                    end else begin
                        vec   <= vec + 2'd1;
                        state <= AFTER_LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arith_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_arith_sweep_checker
// Three checker instances with different settle/pass/width settings, each
// looped back through a behavioural `arithmetic` block with an optional
// stuck-at fault. A cycle-level model predicts all status outputs from the
// elapsed cycles since start; directed runs add literal expectations.
// ---------------------------------------------------------------------------
module tb_arith_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance settings: u0 (S=1,P=1,W=4), u1 (S=2,P=3,W=2), u2 (S=0,P=1,W=4)
    int S_p[3]  = '{1, 2, 0};
    int P_p[3]  = '{1, 3, 1};
    int EW_p[3] = '{4, 2, 4};

    logic start_v[3];
    logic rst_v[3];
    int   fm[3];          // 0: healthy, 1: z stuck at 0, 2: w stuck at 1

    logic       busy_v[3];
    logic       done_v[3];
    logic       pass_v[3];
    logic [3:0] err_v[3];
    logic [1:0] vec_v[3];
    logic       a_v[3];
    logic       b_v[3];
    logic [3:0] err0;
    logic [1:0] err1;
    logic [3:0] err2;

    int n_checks = 0;
    int n_fail   = 0;

    // Golden {w,x,y,z} for vector {a,b}
    function automatic logic [3:0] golden(logic [1:0] v);
        logic a, b;
        a = v[1];
        b = v[0];
        return {a ^ b, a & b, a ^ b, ~a & b};
    endfunction

    function automatic logic [3:0] resp(int mode, logic [1:0] v);
        logic [3:0] r;
        r = golden(v);
        if (mode == 1) r[0] = 1'b0;
        if (mode == 2) r[3] = 1'b1;
        return r;
    endfunction

    function automatic bit mism(int mode, int v);
        return resp(mode, 2'(v)) != golden(2'(v));
    endfunction

    arith_sweep_checker_if ifc0();
    arith_sweep_checker_if ifc1();
    arith_sweep_checker_if ifc2();

    assign {ifc0.w_i, ifc0.x_i, ifc0.y_i, ifc0.z_i} = resp(fm[0], {ifc0.a_o, ifc0.b_o});
    assign {ifc1.w_i, ifc1.x_i, ifc1.y_i, ifc1.z_i} = resp(fm[1], {ifc1.a_o, ifc1.b_o});
    assign {ifc2.w_i, ifc2.x_i, ifc2.y_i, ifc2.z_i} = resp(fm[2], {ifc2.a_o, ifc2.b_o});

`ifdef ARITH_FIRST_FAIL_EN
    logic       fv0, fv1, fv2;
    logic [1:0] fvec0, fvec1, fvec2;
    logic [3:0] fobs0, fobs1, fobs2;
`endif

    arith_sweep_checker #(.SETTLE_CYCLES(1), .NUM_PASSES(1), .ERR_W(4)) u0 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .arith(ifc0),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .err_count(err0), .vec_idx(vec_v[0])
`ifdef ARITH_FIRST_FAIL_EN
        , .fail_valid(fv0), .fail_vec(fvec0), .fail_obs(fobs0)
`endif
    );

    arith_sweep_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(3), .ERR_W(2)) u1 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .arith(ifc1),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .err_count(err1), .vec_idx(vec_v[1])
`ifdef ARITH_FIRST_FAIL_EN
        , .fail_valid(fv1), .fail_vec(fvec1), .fail_obs(fobs1)
`endif
    );

    arith_sweep_checker #(.SETTLE_CYCLES(0), .NUM_PASSES(1), .ERR_W(4)) u2 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .arith(ifc2),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .err_count(err2), .vec_idx(vec_v[2])
`ifdef ARITH_FIRST_FAIL_EN
        , .fail_valid(fv2), .fail_vec(fvec2), .fail_obs(fobs2)
`endif
    );

    assign err_v[0] = err0;
    assign err_v[1] = {2'b00, err1};
    assign err_v[2] = err2;
    assign a_v[0] = ifc0.a_o;
    assign b_v[0] = ifc0.b_o;
    assign a_v[1] = ifc1.a_o;
    assign b_v[1] = ifc1.b_o;
    assign a_v[2] = ifc2.a_o;
    assign b_v[2] = ifc2.b_o;

    // ---------------- behavioural model ----------------
    // m_state: 0 = idle (everything zero), 1 = run started.
    // m_t: clock edges since the start edge, saturating at the run length.
    int m_state[3] = '{0, 0, 0};
    int m_t[3]     = '{0, 0, 0};
    int m_fm[3]    = '{0, 0, 0};

    function automatic int run_len(int i);
        return 4 * P_p[i] * (S_p[i] + 1);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_v[i]) begin
                m_state[i] <= 0;
                m_t[i]     <= 0;
            end else if (start_v[i] && (m_state[i] == 0 || m_t[i] >= run_len(i))) begin
                m_state[i] <= 1;
                m_t[i]     <= 0;
                m_fm[i]    <= fm[i];
            end else if (m_state[i] == 1 && m_t[i] < run_len(i)) begin
                m_t[i] <= m_t[i] + 1;
            end
        end
    end

    // Expected {a,b,busy,done,pass,err[3:0],vec[1:0]}
    function automatic logic [10:0] exp_out(int i);
        int         len;
        int         k;
        int         cnt;
        int         emax;
        logic       done_e;
        logic [1:0] v2;
        if (m_state[i] == 0) return '0;
        len    = run_len(i);
        done_e = (m_t[i] >= len);
        k      = done_e ? 4 * P_p[i] : m_t[i] / (S_p[i] + 1);
        cnt    = 0;
        for (int j = 0; j < k; j++) if (mism(m_fm[i], j % 4)) cnt++;
        emax = (1 << EW_p[i]) - 1;
        if (cnt > emax) cnt = emax;
        v2 = done_e ? 2'd3 : 2'(k % 4);
        return {v2, ~done_e, done_e, done_e && (cnt == 0), 4'(cnt), v2};
    endfunction

    task automatic compare_loop();
        logic [10:0] e;
        logic [10:0] act;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                e   = exp_out(i);
                act = {a_v[i], b_v[i], busy_v[i], done_v[i], pass_v[i], err_v[i], vec_v[i]};
                n_checks++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL model_u%0d t=%0d: got %b expected %b", i, m_t[i], act, e);
                end
            end
        end
    endtask

    // ---------------- directed helpers ----------------
    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Leaves the caller at #1 after the start edge.
    task automatic pulse_start(input int idx);
        @(negedge clk);
        start_v[idx] = 1'b1;
        @(posedge clk);
        #1;
        start_v[idx] = 1'b0;
    endtask

    task automatic wait_done(input int idx, input int bound, output int cyc);
        cyc = 0;
        while (!done_v[idx] && cyc < bound) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check($sformatf("done_reached_u%0d", idx), int'(done_v[idx]), 1);
    endtask

    int seq_a[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 3};

    initial begin
        int cyc;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            rst_v[i]   = 1'b1;
            fm[i]      = 0;
        end
        fork
            compare_loop();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy_u0", int'(busy_v[0]), 0);
        check("reset_err_u0", int'(err0), 0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;

        // A: healthy block, vectors each held 2 cycles, done on edge 8
        @(negedge clk);
        start_v[0] = 1'b1;
        for (int n = 0; n <= 8; n++) begin
            @(posedge clk);
            #1;
            start_v[0] = 1'b0;
            check($sformatf("A_vec_t%0d", n), int'(vec_v[0]), seq_a[n]);
            check($sformatf("A_done_t%0d", n), int'(done_v[0]), (n == 8) ? 1 : 0);
        end
        check("A_err", int'(err0), 0);
        check("A_pass", int'(pass_v[0]), 1);

        // B: z stuck at 0, only vector 01 fails
        fm[0] = 1;
        pulse_start(0);
        wait_done(0, 20, cyc);
        check("B_latency", cyc, 8);
        check("B_err", int'(err0), 1);
        check("B_pass", int'(pass_v[0]), 0);
`ifdef ARITH_FIRST_FAIL_EN
        check("B_fail_valid", int'(fv0), 1);
        check("B_fail_vec", int'(fvec0), 1);
        check("B_fail_obs", int'(fobs0), 4'b1010);
`endif

        // C: reset during CHECK of vector 10, then a clean run
        @(negedge clk);
        fm[0] = 0;
        pulse_start(0);
`ifdef ARITH_FIRST_FAIL_EN
        check("C_fail_cleared", int'(fv0), 0);
`endif
        repeat (5) @(posedge clk);
        #1;
        check("C_in_vec10", int'(vec_v[0]), 2);
        rst_v[0] = 1'b1;
        @(posedge clk);
        #1;
        rst_v[0] = 1'b0;
        check("C_reset_outs", int'({ifc0.a_o, ifc0.b_o, busy_v[0], done_v[0],
                                    pass_v[0], err0, vec_v[0]}), 0);
        pulse_start(0);
        wait_done(0, 20, cyc);
        check("C_pass", int'(pass_v[0]), 1);

        // D: start held throughout with a faulty block
        @(negedge clk);
        fm[0]      = 1;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        wait_done(0, 20, cyc);
        check("D_no_restart_busy", cyc, 8);
        check("D_err_at_done", int'(err0), 1);
        @(posedge clk);
        #1;
        check("D_restart_done", int'(done_v[0]), 0);
        check("D_restart_busy", int'(busy_v[0]), 1);
        check("D_restart_err", int'(err0), 0);
        start_v[0] = 1'b0;
        wait_done(0, 20, cyc);
        @(negedge clk);
        fm[0] = 0;

        // E: w stuck at 1 over 3 passes, 6 raw errors saturate at 3
        fm[1] = 2;
        pulse_start(1);
        wait_done(1, 60, cyc);
        check("E_latency", cyc, 36);
        check("E_err_sat", int'(err1), 3);
        check("E_pass", int'(pass_v[1]), 0);

        // F: zero settle cycles, one cycle per vector
        pulse_start(2);
        check("F_vec_t0", int'(vec_v[2]), 0);
        wait_done(2, 20, cyc);
        check("F_latency", cyc, 4);
        check("F_pass", int'(pass_v[2]), 1);

        repeat (2) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arith_sweep_checker.md
Name: arith_sweep_checker

Overview:
- Synthesizable stimulus/response engine for the 1-bit `arithmetic` block.
- Drives `a`/`b` through all four input combinations and samples the block's `w`/`x`/`y`/`z` outputs after a settle window.
- Compares each sample against the golden function and reports error count and pass/fail.
- Connects directly to the `arithmetic` ports and replaces a hand-written bench sweep for on-board self-test.

Parameters:
- SETTLE_CYCLES, 1: cycles between driving a vector and sampling the response. 0 is legal.
- NUM_PASSES, 1: full 4-vector sweeps per run. Range 1..15.
- ERR_W, 4: width of `err_count`.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  launch a run; sampled only in IDLE or DONE.
- a_o  output  1  stimulus to `arithmetic.a`; registered.
- b_o  output  1  stimulus to `arithmetic.b`; registered.
- w_i  input  1  response `arithmetic.w`.
- x_i  input  1  response `arithmetic.x`.
- y_i  input  1  response `arithmetic.y`.
- z_i  input  1  response `arithmetic.z`.
- busy  output  1  high while a run is in progress.
- done  output  1  high in DONE until the next start or reset.
- pass  output  1  equals done AND (err_count == 0).
- err_count  output  ERR_W  number of mismatching vectors; saturating.
- vec_idx  output  2  index of the current vector, equal to {a_o, b_o}.

Behaviour:
- One clock. Reset is synchronous and active-high. Clock port is `clk`, reset port is `rst`.
- Reset, including mid-run: state goes to IDLE; a_o, b_o, busy, done, pass, err_count, vec_idx, settle counter and pass counter all go to 0.
- Golden function for vector (a, b):
  - w = a XOR b (half-adder sum)
  - x = a AND b (carry)
  - y = a XOR b (half-subtractor difference)
  - z = (NOT a) AND b (borrow)
- Vector order: 00, 01, 10, 11, then repeat for each pass.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE or DONE with start=1:
  - Clear err_count, pass counter and done.
  - Load vector 00 onto a_o/b_o; set busy=1.
  - Next state is SETTLE if SETTLE_CYCLES>0, else CHECK.
- SETTLE:
  - Settle counter increments each cycle.
  - On the cycle it reaches SETTLE_CYCLES-1, the counter clears and the next state is CHECK.
- CHECK:
  - Compare {w_i,x_i,y_i,z_i} against golden({a_o,b_o}) at the clock edge.
  - Any bit differing adds 1 to err_count. This is one increment per vector, not per bit.
  - err_count holds at 2^ERR_W-1 (saturation).
  - If this is vector 11 of pass NUM_PASSES-1: next state DONE, busy=0, done=1; a_o/b_o hold 11.
  - If vector 11 of an earlier pass: increment the pass counter and load 00.
  - Otherwise load the next vector.
  - After loading a vector, go to SETTLE or CHECK as in IDLE.
- Latency: from the start edge to done=1 is exactly NUM_PASSES*4*(SETTLE_CYCLES+1) cycles.
- start while busy: ignored.
- start held high in DONE: immediate restart, with done dropping on the same edge.
- The comparison in a CHECK cycle is always counted, even if start is asserted in that cycle.
- Inputs w_i..z_i are sampled only in CHECK; values in any other state have no effect.

Optional Feature:
- Macro: ARITH_FIRST_FAIL_EN.
- When defined, the block adds two outputs:
  - fail_vec (2 bits): the vector at the first mismatch in the run.
  - fail_obs (4 bits): the {w,x,y,z} value observed at that mismatch.
- Both new outputs and a valid flag are captured only at the first mismatch of a run.
- Both are cleared on reset and on start, and hold their value afterwards.
- A third new output, fail_valid, is high once a capture has occurred.
- When not defined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Correct DUT, SETTLE_CYCLES=1, NUM_PASSES=1:
  - start pulse → vectors 00, 01, 10, 11, each held 2 cycles.
  - done=1 exactly 8 cycles after the start edge; err_count=0; pass=1.
- DUT with z forced to 0:
  - Only vector 01 mismatches → err_count=1, pass=0.
  - With ARITH_FIRST_FAIL_EN: fail_vec=01, fail_obs=1010, fail_valid=1.
- Saturation: ERR_W=2, NUM_PASSES=3, w forced to 1 (mismatches at 00 and 11) → 6 raw errors, err_count saturates at 3.
- Reset mid-run: rst=1 during CHECK of vector 10 → next cycle all outputs are 0 and state is IDLE; a new start completes normally with pass=1.
- start handling:
  - start held high throughout the run → no restart while busy.
  - Auto-restart from DONE: done is high 1 cycle, err_count clears.
- SETTLE_CYCLES=0 → each vector is held 1 cycle; done after 4 cycles; pass=1 with a correct DUT.
